// File: rtl/alu_exec_pipe.sv
// Pipelined execute-stage ALU with a valid/ready handshake and tag passthrough.
// Computes in stage 1; the later stages only delay the result. Also counts delivered overflows.
module alu_exec_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [3:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_overflow,
  output logic                     out_zero,
  output logic                     out_illegal,
  output logic [TAG_W-1:0]         out_tag,
  input  logic                     ovf_clear,
  output logic [CNT_W-1:0]         ovf_count
);

  localparam int M = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             zero;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } stg_t;

  stg_t               r_stg [LATENCY];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] w_adv;
  logic [CNT_W-1:0]   r_cnt;

  stg_t               w_new;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic               w_gt;
  logic               w_lt;
  logic               w_gtu;
  logic               w_ltu;
  logic               w_cnt_inc;

  assign w_sum  = in_a + in_b;
  assign w_diff = in_a - in_b;
  assign w_gt   = $signed(in_a) > $signed(in_b);
  assign w_lt   = $signed(in_a) < $signed(in_b);
  assign w_gtu  = in_a > in_b;
  assign w_ltu  = in_a < in_b;

  always_comb begin
    w_new     = '0;
    w_new.tag = in_tag;
    unique case (in_op)
      4'd0: begin
        w_new.res = w_sum;
        w_new.ovf = (in_a[M] == in_b[M]) && (w_sum[M] != in_a[M]);
      end
      4'd1: begin
        w_new.res = w_diff;
        w_new.ovf = (in_a[M] != in_b[M]) && (w_diff[M] != in_a[M]);
      end
      4'd2:  w_new.res = in_a & in_b;
      4'd3:  w_new.res = in_a | in_b;
      4'd4:  w_new.res = in_a << in_shamt;
      4'd5:  w_new.res = in_a >> in_shamt;
      4'd6:  w_new.res = $unsigned($signed(in_a) >>> in_shamt);
      4'd7:  w_new.res = {{(WIDTH-1){1'b0}}, w_gt};
      4'd8:  w_new.res = {{(WIDTH-1){1'b0}}, w_lt};
      4'd9:  w_new.res = in_a ^ in_b;
      4'd10: w_new.res = ~(in_a | in_b);
      4'd11: w_new.res = {{(WIDTH-1){1'b0}}, w_gtu};
      4'd12: w_new.res = {{(WIDTH-1){1'b0}}, w_ltu};
      default: w_new.ill = 1'b1;
    endcase
    w_new.zero = (w_new.res == '0);
  end

  // A stage may advance if it or any stage after it has a hole, or the
  // consumer takes the head; walking back from the tail avoids a comb loop.
  always_comb begin
    logic go;
    go    = out_ready;
    w_adv = '0;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      go       = go || !r_vld[k];
      w_adv[k] = go;
    end
  end

  assign in_ready = w_adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < LATENCY; k++) r_stg[k] <= '0;
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) r_stg[0] <= w_new;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) r_stg[k] <= r_stg[k-1];
        end
      end
    end
  end

  assign out_valid    = r_vld[LATENCY-1];
  assign out_result   = r_stg[LATENCY-1].res;
  assign out_overflow = r_stg[LATENCY-1].ovf;
  assign out_zero     = r_stg[LATENCY-1].zero;
  assign out_illegal  = r_stg[LATENCY-1].ill;
  assign out_tag      = r_stg[LATENCY-1].tag;

  assign w_cnt_inc = out_valid && out_ready && out_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (ovf_clear) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ovf_count = r_cnt;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Bench for alu_exec_pipe: directed cases, then random traffic.
// Results come from a queue-based reference model.
module tb_alu_exec_pipe;

  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int TW  = 5;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [3:0]    in_op;
  logic [4:0]    in_shamt;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_overflow;
  logic          out_zero;
  logic          out_illegal;
  logic [TW-1:0] out_tag;
  logic          ovf_clear;
  logic [CW-1:0] ovf_count;

  alu_exec_pipe #(.WIDTH(W), .LATENCY(LAT), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_zero(out_zero), .out_illegal(out_illegal),
    .out_tag(out_tag),
    .ovf_clear(ovf_clear), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic          ovf;
    logic          zero;
    logic          ill;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          m_cnt = 0;
  int          n_dlv = 0;
  bit          last_acc = 0;
  bit          stall_prev = 0;
  logic [40:0] saved;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [W-1:0] a, b,
                                 input logic [4:0] sh,
                                 input logic [TW-1:0] tag);
    exp_t        e;
    longint      sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    e.res = '0; e.ovf = 0; e.ill = 0; e.tag = tag; e.cyc = 0;
    case (op)
      4'd0: begin
        r = sa + sb;
        e.res = r[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd1: begin
        r = sa - sb;
        e.res = r[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4: begin
        p = {32'b0, a} * (64'd1 << sh);
        e.res = p[31:0];
      end
      4'd5:  e.res = a / (32'd1 << sh);
      4'd6: begin
        r = sa >>> sh;
        e.res = r[31:0];
      end
      4'd7:  e.res = (sa > sb) ? 1 : 0;
      4'd8:  e.res = (sa < sb) ? 1 : 0;
      4'd9:  e.res = a ^ b;
      4'd10: e.res = ~(a | b);
      4'd11: e.res = (a > b) ? 1 : 0;
      4'd12: e.res = (a < b) ? 1 : 0;
      default: e.ill = 1;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    bit   acc, dlv, exp_ov;
    @(negedge clk);
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    chk("in_ready", in_ready, (q.size() < LAT) || out_ready);
    exp_ov = (q.size() > 0) && ((cyc - q[0].cyc) >= LAT);
    chk("out_valid", out_valid, exp_ov);
    if (stall_prev)
      chk("stall_hold", {out_result, out_overflow, out_zero,
          out_illegal, out_tag, out_valid}, {saved, 1'b1});
    chk("ovf_count", ovf_count, m_cnt);
    if (ovf_clear) m_cnt = 0;
    if (dlv && q.size() > 0) begin
      e = q.pop_front();
      chk("result", out_result, e.res);
      chk("flags", {out_overflow, out_zero, out_illegal},
          {e.ovf, e.zero, e.ill});
      chk("tag", out_tag, e.tag);
      n_dlv++;
      if (!ovf_clear && e.ovf && m_cnt < 3) m_cnt++;
    end
    if (acc) begin
      e = model(in_op, in_a, in_b, in_shamt, in_tag);
      e.cyc = cyc;
      q.push_back(e);
    end
    stall_prev = out_valid && !out_ready;
    saved = {out_result, out_overflow, out_zero, out_illegal, out_tag};
    last_acc = acc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, b,
                      input logic [4:0] sh, input logic [TW-1:0] tag);
    int n;
    in_valid = 1; in_op = op; in_a = a; in_b = b;
    in_shamt = sh; in_tag = tag;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic directed(input string nm, input logic [3:0] op,
                          input logic [W-1:0] a, b, input logic [4:0] sh,
                          input logic [TW-1:0] tag, input logic [W-1:0] er,
                          input logic eo, ez, ei, input logic clr);
    send(op, a, b, sh, tag);
    tick();
    chk({nm, "_vld"}, out_valid, 1);
    chk({nm, "_res"}, out_result, er);
    chk({nm, "_flg"}, {out_overflow, out_zero, out_illegal}, {eo, ez, ei});
    chk({nm, "_tag"}, out_tag, tag);
    ovf_clear = clr;
    tick();
    ovf_clear = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, c;
    bit  saw_block;
    rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0;
    in_shamt = 0; in_tag = 0; out_ready = 1; ovf_clear = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {out_result, out_overflow, out_zero, out_illegal,
        out_tag}, 0);
    chk("rst_ovf_count", ovf_count, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    directed("add", 4'd0, 32'd1, 32'd5, 5'd0, 5'd4, 32'd6, 0, 0, 0, 0);
    directed("sub", 4'd1, 32'd5, 32'd8, 5'd0, 5'd1, 32'hFFFFFFFD,
             0, 0, 0, 0);
    directed("addovf", 4'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd2,
             32'h80000000, 1, 0, 0, 0);
    chk("cnt_one", ovf_count, 1);
    directed("subovf", 4'd1, 32'd0, 32'h80000000, 5'd0, 5'd3,
             32'h80000000, 1, 0, 0, 0);
    directed("subzero", 4'd1, 32'd5, 32'd5, 5'd0, 5'd5, 32'd0,
             0, 1, 0, 0);
    directed("lt", 4'd8, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd6, 32'd1,
             0, 0, 0, 0);
    directed("ltu", 4'd12, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd7, 32'd0,
             0, 1, 0, 0);
    directed("gtu", 4'd11, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd8, 32'd1,
             0, 0, 0, 0);
    directed("sra", 4'd6, 32'h80000000, 32'd0, 5'd4, 5'd9, 32'hF8000000,
             0, 0, 0, 0);
    directed("srl", 4'd5, 32'h80000000, 32'd0, 5'd4, 5'd10, 32'h08000000,
             0, 0, 0, 0);
    directed("ill", 4'd14, 32'h1234, 32'h5678, 5'd0, 5'd11, 32'd0,
             0, 1, 1, 0);

    for (int i = 0; i < 3; i++)
      directed("sat", 4'd0, 32'h80000000, 32'h80000000, 5'd0, 5'd12,
               32'd0, 1, 1, 0, 0);
    chk("cnt_sat", ovf_count, 3);
    directed("clr", 4'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 5'd13,
             32'hFFFFFFFE, 1, 0, 0, 1);
    chk("cnt_clr", ovf_count, 0);

    k = 0; c = 0; saw_block = 0; n_dlv = 0;
    while ((k < 6 || q.size() > 0) && c < 40) begin
      in_valid = (k < 6);
      in_op = 4'd0; in_a = k; in_b = 32'd100; in_tag = k[4:0];
      out_ready = !(c >= 3 && c <= 6);
      if (!in_ready) saw_block = 1;
      tick();
      if (last_acc) k++;
      c++;
    end
    in_valid = 0; out_ready = 1;
    chk("bp_blocked", saw_block, 1);
    chk("bp_delivered", n_dlv, 6);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: in_a = 32'h80000000;
        1: in_a = 32'h7FFFFFFF;
        default: in_a = $urandom;
      endcase
      in_b      = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
      in_shamt  = 5'($urandom_range(0, 31));
      in_tag    = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clear = ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid = 0; out_ready = 1; ovf_clear = 0;
    repeat (5) tick();
    chk("drain_empty", q.size(), 0);

    in_valid = 1; in_op = 4'd0; in_a = 32'h7FFFFFFF; in_b = 32'd1;
    in_tag = 5'd20;
    repeat (2) tick();
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_fields", {out_result, out_overflow, out_zero,
        out_illegal, out_tag}, 0);
    chk("mid_rst_cnt", ovf_count, 0);
    q.delete();
    m_cnt = 0; stall_prev = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", in_ready, 1);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle ALU: WIDTH-bit datapath, LATENCY-stage pipeline with valid/ready handshake and backpressure, tag passthrough.
- Corrected overflow (computed from the same operation's sum, not the previous result), zero flag, unsigned compares, XOR/NOR, illegal-op flag, saturating overflow counter.
- Sits between regfile read/operand mux and writeback mux in the execute stage.

Parameters:
WIDTH, 32, operand/result width (>=8)
LATENCY, 2, pipeline stages from accept to output (1..4)
TAG_W, 5, sideband tag width (destination register index)
CNT_W, 8, overflow event counter width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  pipeline can accept this cycle
in_a  input  WIDTH  operand A (signed view for signed ops)
in_b  input  WIDTH  operand B
in_op  input  4  opcode
in_shamt  input  $clog2(WIDTH)  shift amount
in_tag  input  TAG_W  sideband, returned unchanged
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_overflow  output  1  signed overflow (ADD/SUB only, else 0)
out_zero  output  1  out_result == 0
out_illegal  output  1  opcode 13..15
out_tag  output  TAG_W  tag of this result
ovf_clear  input  1  synchronous clear of ovf_count
ovf_count  output  CNT_W  saturating count of delivered overflowing results

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 GT signed, 8 LT signed, 9 XOR, 10 NOR, 11 GTU, 12 LTU; 13-15 illegal -> result 0, out_illegal=1, overflow 0.
- Compares yield 1 or 0 zero-extended to WIDTH. SRA replicates in_a MSB.
- ADD overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]. SUB overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB] (correct for b = most-negative). Results wrap modulo 2^WIDTH.
- All computation in stage 1 (combinational from in_*, registered on accept); stages 2..LATENCY delay only. Output fields driven directly from last stage registers.
- Handshake: transfer in when in_valid && in_ready; out when out_valid && out_ready. Stage k advances when empty or stage k+1 advances; last stage advances when out_ready or empty. in_ready = stage 1 empty or advancing (combinational from out_ready; no combinational in_valid->out_valid path).
- Latency: with out_ready held 1, op accepted at edge N appears with out_valid=1 after edge N+LATENCY-1 (LATENCY=2: visible cycle after accept, transferred on the next edge). Throughput 1/cycle; bubbles collapse under stall.
- Output fields held stable while out_valid && !out_ready. Ordering preserved; no drop, no duplication.
- ovf_count increments by 1 on each output transfer with out_overflow=1; saturates at 2^CNT_W-1. ovf_clear has priority over simultaneous increment (result 0).
- Reset (async assert, any time incl. mid-pipeline): all stage valids 0, out_valid 0, out_result 0, out_overflow 0, out_zero 0, out_illegal 0, out_tag 0, ovf_count 0; in-flight ops discarded. in_ready=1 the first cycle after deassertion.

Test Plan:
- WIDTH=32, LATENCY=2, out_ready=1: ADD 1+5 tag 4 -> after 2 edges result 6, tag 4, overflow 0, zero 0; SUB 5-8 -> 0xFFFFFFFD, overflow 0.
- ADD 0x7FFFFFFF+1 -> 0x80000000, overflow 1, ovf_count 1; SUB 0-0x80000000 -> 0x80000000, overflow 1; SUB 5-5 -> 0, zero 1.
- Compares/shifts: a=0xFFFFFFFF,b=1: LT->1, LTU->0, GTU->1; SRA shamt 4 of 0x80000000 -> 0xF8000000; SRL -> 0x08000000; op 14 -> result 0, illegal 1.
- Backpressure: stream 6 ADDs tags 0..5 back-to-back, out_ready low cycles 3-6 -> in_ready drops once both stages full, outputs stable while stalled, all 6 delivered in order, none lost.
- Counter: CNT_W=2, 5 overflowing transfers -> ovf_count saturates at 3; ovf_clear in same cycle as an overflowing transfer -> 0.
- Assert rst_n low with 2 ops in flight -> out_valid, ovf_count, all outputs 0 immediately; after release no stale result emerges.
